draw_text_overlay: RTL

DRAW_TEXT_OVERLAY -- requirements
Module: draw_text_overlay

---
 rtl/draw_text_overlay_if.sv | 13 +
 rtl/draw_text_overlay.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/draw_text_overlay_if.sv
// VGA timing/pixel bundle shared by the overlay input and output ports.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
  modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_text_overlay.sv
// draw_text_overlay: N_BOXES character-cell text boxes (8x16 glyphs) drawn
// over a VGA stream with a fixed 2-clock latency. Box geometry/colour is
// sampled once per frame at (0,0). Optional blinking is enabled with the
// macro DRAW_TEXT_BLINK_EN.

// Per-box hit test and character addressing for the current pixel.
module draw_text_box_hit #(
  parameter int COLS = 16,
  parameter int ROWS = 16
) (
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [10:0] bx,
  input  logic [10:0] by,
  input  logic        en,
  input  logic        suppress,
  output logic        hit,
  output logic [7:0]  xy,
  output logic [3:0]  line,
  output logic [2:0]  bit_idx
);
  logic [11:0] dx, dy;
  logic        in_x, in_y;

  // 12-bit offsets; screen coordinates >= 1024 are clipped, never wrapped
  always_comb begin
    dx      = {1'b0, hcount} - {1'b0, bx};
    dy      = {1'b0, vcount} - {1'b0, by};
    in_x    = (hcount >= bx) && (dx < 12'(8 * COLS)) && !hcount[10];
    in_y    = (vcount >= by) && (dy < 12'(16 * ROWS)) && !vcount[10];
    hit     = en && !suppress && in_x && in_y;
    bit_idx = dx[2:0];
    xy      = '0;
    line    = '0;
    if (hit) begin
      xy   = {dy[7:4] & 4'(ROWS - 1), dx[6:3] & 4'(COLS - 1)};
      line = dy[3:0];
    end
  end
endmodule

module draw_text_overlay #(
  parameter int N_BOXES      = 2,
  parameter int COLS         = 16,
  parameter int ROWS         = 16,
  parameter int BLINK_PERIOD = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  vga_if.in                          in,
  vga_if.out                         out,
  input  logic [N_BOXES-1:0][10:0]   box_x,
  input  logic [N_BOXES-1:0][10:0]   box_y,
  input  logic [N_BOXES-1:0]         box_en,
  input  logic [N_BOXES-1:0]         box_blink,
  input  logic [N_BOXES-1:0][11:0]   fg_rgb,
  output logic [N_BOXES-1:0][7:0]    char_xy,
  output logic [N_BOXES-1:0][3:0]    char_line,
  input  logic [N_BOXES-1:0][7:0]    char_pixels
);
  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  logic [N_BOXES-1:0][10:0] sh_x, sh_y;
  logic [N_BOXES-1:0]       sh_en;
  logic [N_BOXES-1:0][11:0] sh_fg;

  logic [N_BOXES-1:0]       suppress;
  logic [N_BOXES-1:0]       hit_c;
  logic [N_BOXES-1:0][7:0]  xy_c;
  logic [N_BOXES-1:0][3:0]  line_c;
  logic [N_BOXES-1:0][2:0]  bit_c;

  vga_t                     s1, s2;
  logic [N_BOXES-1:0]       s1_hit;
  logic [N_BOXES-1:0][2:0]  s1_bit;
  logic [11:0]              rgb_nxt;

  // Box parameters are frozen for the whole frame, captured at (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x  <= '0;
      sh_y  <= '0;
      sh_en <= '0;
      sh_fg <= '0;
    end else if (in.vcount == 11'd0 && in.hcount == 11'd0) begin
      sh_x  <= box_x;
      sh_y  <= box_y;
      sh_en <= box_en;
      sh_fg <= fg_rgb;
    end
  end

`ifdef DRAW_TEXT_BLINK_EN
  logic        vsync_d;
  logic        blink_phase;
  logic [15:0] frame_cnt;

  // Frame counter on vsync rising edges; phase flips each BLINK_PERIOD frames
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d     <= 1'b0;
      blink_phase <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      vsync_d <= in.vsync;
      if (in.vsync && !vsync_d) begin
        if (frame_cnt == 16'(BLINK_PERIOD - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

  assign suppress = box_blink & {N_BOXES{blink_phase}};
`else
  logic unused_blink;
  assign unused_blink = ^box_blink;
  assign suppress     = '0;
`endif

  for (genvar g = 0; g < N_BOXES; g++) begin : g_box
    draw_text_box_hit #(.COLS(COLS), .ROWS(ROWS)) u_hit (
      .hcount   (in.hcount),
      .vcount   (in.vcount),
      .bx       (sh_x[g]),
      .by       (sh_y[g]),
      .en       (sh_en[g]),
      .suppress (suppress[g]),
      .hit      (hit_c[g]),
      .xy       (xy_c[g]),
      .line     (line_c[g]),
      .bit_idx  (bit_c[g])
    );
  end

  // Stage 1: delay the stream, present glyph address to the font lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s1_hit    <= '0;
      s1_bit    <= '0;
      char_xy   <= '0;
      char_line <= '0;
    end else begin
      s1        <= '{vcount: in.vcount, hcount: in.hcount, vsync: in.vsync,
                     vblnk: in.vblnk, hsync: in.hsync, hblnk: in.hblnk,
                     rgb: in.rgb};
      s1_hit    <= hit_c;
      s1_bit    <= bit_c;
      char_xy   <= xy_c;
      char_line <= line_c;
    end
  end

  // Glyph colour of the lowest-index lit box wins; blanking passes rgb through
  always_comb begin
    rgb_nxt = s1.rgb;
    if (!s1.hblnk && !s1.vblnk) begin
      for (int i = N_BOXES - 1; i >= 0; i--) begin
        if (s1_hit[i] && char_pixels[i][3'd7 - s1_bit[i]])
          rgb_nxt = sh_fg[i];
      end
    end
  end

  // Stage 2: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
    end else begin
      s2     <= s1;
      s2.rgb <= rgb_nxt;
    end
  end

  assign out.vcount = s2.vcount;
  assign out.hcount = s2.hcount;
  assign out.vsync  = s2.vsync;
  assign out.vblnk  = s2.vblnk;
  assign out.hsync  = s2.hsync;
  assign out.hblnk  = s2.hblnk;
  assign out.rgb    = s2.rgb;
endmodule
